pipe_stage_chain: RTL

//  Parametrised successor to the fixed-width IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_stage_cell.sv | 121 ++++++++++++
 rtl/pipe_stage_chain.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline register chain.
// Holds the depth limit, the per-cell handshake state encoding and a
// constant-evaluable clog2 used to size the occupancy counter.
package pipe_pkg;

  localparam int PIPE_MAX_DEPTH = 8;

  // Per-cell handshake state. BOTH is only reachable when the skid
  // register exists; without it a cell is either EMPTY or MAIN.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } cell_state_e;

  // Ceiling log2, usable in parameter/localparam expressions.
  // clog2(1)=0, clog2(2)=1, clog2(5)=3, clog2(17)=5.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One stage of the pipeline register chain.
// Handshake: a transfer happens on the rising edge where valid and ready
// are both high on the same link; valid never depends on ready, and a
// presented entry stays stable until it is taken.
// Build option PIPE_STAGE_CHAIN_SKID_EN adds a skid register so that the
// upstream ready is a pure register output (ready = !skid valid); without
// it ready is !valid || downstream ready, a combinational path.
// Flush empties the cell on the next edge and wins over any transfer;
// payload registers keep their contents on flush.
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_ready_i,
  output logic [WIDTH-1:0] dn_data_o,
  output cell_state_e      state_o
);

  cell_state_e      state_q;
  logic [WIDTH-1:0] main_q;
  logic             accept;
  logic             drain;

  // The main register is always the entry presented downstream.
  assign state_o   = state_q;
  assign dn_data_o = main_q;
  assign accept    = up_valid_i && up_ready_o;
  assign drain     = (state_q != EMPTY) && dn_ready_i;

`ifdef PIPE_STAGE_CHAIN_SKID_EN

  logic [WIDTH-1:0] skid_q;

  // Ready comes straight from state: only a full skid blocks the input.
  assign up_ready_o = (state_q != BOTH);

  // Cell FSM with main and skid registers; flush empties both.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= up_data_i;
            state_q <= MAIN;
          end
        end
        MAIN: begin
          if (accept && drain) begin
            main_q <= up_data_i;
          end else if (accept) begin
            // Downstream stalled: park the new entry behind the head.
            skid_q  <= up_data_i;
            state_q <= BOTH;
          end else if (drain) begin
            state_q <= EMPTY;
          end
        end
        BOTH: begin
          if (drain) begin
            main_q  <= skid_q;
            state_q <= MAIN;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

`else

  // Accept when empty, or when the held entry leaves this same edge.
  assign up_ready_o = (state_q == EMPTY) || dn_ready_i;

  // Cell FSM with a single register; flush empties it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= up_data_i;
            state_q <= MAIN;
          end
        end
        MAIN: begin
          if (accept) begin
            // Accept in MAIN implies the head drained this edge.
            main_q <= up_data_i;
          end else if (drain) begin
            state_q <= EMPTY;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

`endif

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of DEPTH pipeline register stages of WIDTH bits with a
// valid/ready handshake per stage, synchronous flush and a registered
// occupancy count. DEPTH=1 behaves as a plain pipeline register.
// Handshake: input transfer when in_valid_i && in_ready_o, output transfer
// when out_valid_o && out_ready_i, both on the same rising edge; a held
// head entry stays stable while out_ready_i is low.
// Build option macro PIPE_STAGE_CHAIN_SKID_EN: each stage gains a skid
// register (capacity 2*DEPTH, registered ready per stage); undefined gives
// one register per stage (capacity DEPTH, combinational ready chain).
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1,
  parameter int OCC_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [OCC_W-1:0] occupancy_o
);

`ifdef PIPE_STAGE_CHAIN_SKID_EN
  localparam int CAPACITY = 2 * DEPTH;
`else
  localparam int CAPACITY = DEPTH;
`endif
  localparam int OCC_MIN = clog2(CAPACITY + 1);

  // Elaboration-time guards on the configuration.
  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be 1..%0d", PIPE_MAX_DEPTH);
  end
  if (OCC_W < OCC_MIN) begin : g_bad_occ_w
    $error("pipe_stage_chain: OCC_W must be at least %0d", OCC_MIN);
  end

  logic             in_fire;
  logic             out_fire;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Each generate block owns its own link signals so the ready chain is a
  // set of distinct nets rather than one self-referencing vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_cell
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_data;
    logic             dn_ready;
    logic [WIDTH-1:0] dn_data;
    cell_state_e      state;

    if (k == 0) begin : g_head_in
      assign up_valid = in_fire;
      assign up_data  = in_data_i;
    end else begin : g_link_in
      assign up_valid = (g_cell[k-1].state != EMPTY);
      assign up_data  = g_cell[k-1].dn_data;
    end

    if (k == DEPTH - 1) begin : g_tail_out
      assign dn_ready = out_ready_i;
    end else begin : g_link_out
      assign dn_ready = g_cell[k+1].up_ready;
    end

    pipe_stage_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .up_valid_i (up_valid),
      .up_ready_o (up_ready),
      .up_data_i  (up_data),
      .dn_ready_i (dn_ready),
      .dn_data_o  (dn_data),
      .state_o    (state)
    );
  end

  // Input is refused during reset and in a flush cycle.
  assign in_ready_o  = g_cell[0].up_ready && !flush_i && !rst_i;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_valid_o = (g_cell[DEPTH-1].state != EMPTY);
  assign out_data_o  = g_cell[DEPTH-1].dn_data;
  assign out_fire    = out_valid_o && out_ready_i;
  assign occupancy_o = occ_q;

  // Occupancy next value: flush clears, otherwise +accepted -delivered.
  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule
